// File: rtl/pulse_div.sv
// pulse_div: routes every D-th input pulse to outd_o and the rest to outn_o.
// Define PULSE_DIV_OUTD_CNT_EN to enable the saturating OUTD_CNT pulse counter.
module pulse_div (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inp_i,
    input  logic        enable_i,
    input  logic [31:0] DIVISOR,
    input  logic        DIVISOR_WSTB,
    input  logic        FIRST_PULSE,
    input  logic        FIRST_PULSE_WSTB,
    output logic        outd_o,
    output logic        outn_o,
    output logic [31:0] COUNT,
    output logic [31:0] OUTD_CNT
);
    logic        prev, blk, en_q, outd, outn, en_rise, rise, hit;
    logic [31:0] count, d_m1, init, base;
    always_comb begin
        d_m1    = (DIVISOR == 32'd0) ? 32'd0 : DIVISOR - 32'd1;
        init    = FIRST_PULSE ? d_m1 : 32'd0;
        en_rise = enable_i & ~en_q;
        base    = (DIVISOR_WSTB | FIRST_PULSE_WSTB | en_rise) ? init : count;
        rise    = enable_i & inp_i & ~prev & ~blk;
        // out-of-range counts left by a divisor change also route to outd
        hit     = base >= d_m1;
    end
    // blk suppresses a pulse that was already high across reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outd  <= 1'b0;
            outn  <= 1'b0;
            prev  <= 1'b0;
            blk   <= inp_i;
            en_q  <= 1'b0;
            count <= init;
        end else begin
            prev <= inp_i;
            en_q <= enable_i;
            blk  <= blk & inp_i;
            if (!enable_i) begin
                outd  <= 1'b0;
                outn  <= 1'b0;
                count <= init;
            end else if (rise) begin
                outd  <= hit;
                outn  <= ~hit;
                count <= hit ? 32'd0 : base + 32'd1;
            end else begin
                outd  <= outd & inp_i;
                outn  <= outn & inp_i;
                count <= base;
            end
        end
    end
    assign outd_o = outd;
    assign outn_o = outn;
    assign COUNT  = count;
`ifdef PULSE_DIV_OUTD_CNT_EN
    logic [31:0] outd_cnt, cnt_base;
    always_comb cnt_base = en_rise ? 32'd0 : outd_cnt;
    always_ff @(posedge clk_i) begin
        if (reset_i)
            outd_cnt <= 32'd0;
        else if (enable_i)
            outd_cnt <= (rise && hit && cnt_base != 32'hFFFF_FFFF) ? cnt_base + 32'd1 : cnt_base;
    end
    assign OUTD_CNT = outd_cnt;
`else
    assign OUTD_CNT = 32'd0;
`endif
endmodule

// File: tb/tb_pulse_div.sv
// tb_pulse_div: table-driven cycle vectors plus a hand-written mid-pulse reset sequence.
module tb_pulse_div;
    typedef struct {
        logic        inp, en;
        logic [31:0] div;
        logic        first, dstb, fstb, d, n;
        logic [31:0] cnt;
    } vec_t;
`ifdef PULSE_DIV_OUTD_CNT_EN
    localparam bit OC_EN = 1'b1;
`else
    localparam bit OC_EN = 1'b0;
`endif
    logic        clk = 1'b0, reset_i, inp_i, enable_i, DIVISOR_WSTB, FIRST_PULSE, FIRST_PULSE_WSTB;
    logic        outd_o, outn_o;
    logic [31:0] DIVISOR, COUNT, OUTD_CNT;
    int          total = 0, bad = 0;
    vec_t        q[$];
    logic [31:0] cdiv;
    logic        cfirst;
    pulse_div dut (
        .clk_i(clk), .reset_i(reset_i), .inp_i(inp_i), .enable_i(enable_i),
        .DIVISOR(DIVISOR), .DIVISOR_WSTB(DIVISOR_WSTB),
        .FIRST_PULSE(FIRST_PULSE), .FIRST_PULSE_WSTB(FIRST_PULSE_WSTB),
        .outd_o(outd_o), .outn_o(outn_o), .COUNT(COUNT), .OUTD_CNT(OUTD_CNT)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic add(input logic inp, input logic en, input logic [31:0] div, input logic first,
                       input logic dstb, input logic fstb, input logic d, input logic n, input logic [31:0] cnt);
        vec_t v;
        v.inp = inp; v.en = en; v.div = div; v.first = first; v.dstb = dstb; v.fstb = fstb;
        v.d = d; v.n = n; v.cnt = cnt;
        q.push_back(v);
        cdiv = div;
        cfirst = first;
    endtask
    // two cycles high, two low; r=1 routes to outd
    task automatic pulse(input logic r, input logic [31:0] c);
        add(1, 1, cdiv, cfirst, 0, 0, r, !r, c);
        add(1, 1, cdiv, cfirst, 0, 0, r, !r, c);
        add(0, 1, cdiv, cfirst, 0, 0, 0, 0, c);
        add(0, 1, cdiv, cfirst, 0, 0, 0, 0, c);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic        prev_en, prev_d;
        int          oc;
        reset_i = 1; inp_i = 0; enable_i = 0; DIVISOR = 3; FIRST_PULSE = 1;
        DIVISOR_WSTB = 0; FIRST_PULSE_WSTB = 0;
        tick(); tick();
        chk("reset_count_fp1", COUNT, 2);
        chk("reset_outd", {31'd0, outd_o}, 0);
        chk("reset_outn", {31'd0, outn_o}, 0);
        chk("reset_outd_cnt", OUTD_CNT, 0);
        @(negedge clk); FIRST_PULSE = 0;
        tick();
        chk("reset_count_fp0", COUNT, 0);
        // divisor 3, first to outn
        cdiv = 3; cfirst = 0;
        pulse(0, 1); pulse(0, 2); pulse(1, 0); pulse(0, 1); pulse(0, 2); pulse(1, 0);
        // first pulse to outd
        add(0, 1, 3, 1, 0, 1, 0, 0, 2);
        pulse(1, 0); pulse(0, 1); pulse(0, 2); pulse(1, 0);
        // divisor 0 acts as 1
        add(0, 1, 0, 1, 1, 0, 0, 0, 0);
        pulse(1, 0); pulse(1, 0); pulse(1, 0);
        // strobe coinciding with an edge
        add(0, 1, 4, 0, 1, 0, 0, 0, 0);
        pulse(0, 1); pulse(0, 2);
        add(1, 1, 2, 0, 1, 0, 0, 1, 1);
        add(1, 1, 2, 0, 0, 0, 0, 1, 1);
        add(0, 1, 2, 0, 0, 0, 0, 0, 1);
        add(0, 1, 2, 0, 0, 0, 0, 0, 1);
        pulse(1, 0);
        // count left out of range by a divisor change
        add(0, 1, 8, 0, 1, 0, 0, 0, 0);
        pulse(0, 1); pulse(0, 2); pulse(0, 3); pulse(0, 4); pulse(0, 5);
        cdiv = 3;
        pulse(1, 0); pulse(0, 1);
        // enable drop while outd high, then re-enable with new first-pulse setting
        add(0, 1, 3, 0, 1, 0, 0, 0, 0);
        pulse(0, 1); pulse(0, 2);
        add(1, 1, 3, 0, 0, 0, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0, 2);
        add(0, 1, 3, 1, 0, 0, 0, 0, 2);
        pulse(1, 0); pulse(0, 1);
        // input already high when enable rises
        add(1, 0, 3, 1, 0, 0, 0, 0, 2);
        add(1, 1, 3, 1, 0, 0, 0, 0, 2);
        add(1, 1, 3, 1, 0, 0, 0, 0, 2);
        add(0, 1, 3, 1, 0, 0, 0, 0, 2);
        pulse(1, 0);
        @(negedge clk); reset_i = 0;
        prev_en = 0; prev_d = 0; oc = 0;
        foreach (q[i]) begin
            @(negedge clk);
            inp_i = q[i].inp; enable_i = q[i].en; DIVISOR = q[i].div; FIRST_PULSE = q[i].first;
            DIVISOR_WSTB = q[i].dstb; FIRST_PULSE_WSTB = q[i].fstb;
            tick();
            if (q[i].en && !prev_en) oc = 0;
            if (q[i].d && !prev_d) oc++;
            prev_en = q[i].en; prev_d = q[i].d;
            chk($sformatf("v%0d_outd", i), {31'd0, outd_o}, {31'd0, q[i].d});
            chk($sformatf("v%0d_outn", i), {31'd0, outn_o}, {31'd0, q[i].n});
            chk($sformatf("v%0d_count", i), COUNT, q[i].cnt);
            chk($sformatf("v%0d_outd_cnt", i), OUTD_CNT, OC_EN ? oc : 0);
        end
        // reset mid-pulse with input held high
        @(negedge clk); inp_i = 1; enable_i = 1; DIVISOR = 1; FIRST_PULSE = 0; DIVISOR_WSTB = 1;
        tick();
        chk("pre_reset_outd", {31'd0, outd_o}, 1);
        chk("pre_reset_outd_cnt", OUTD_CNT, OC_EN ? oc + 1 : 0);
        @(negedge clk); DIVISOR_WSTB = 0; reset_i = 1;
        tick();
        chk("mid_reset_outd", {31'd0, outd_o}, 0);
        chk("mid_reset_outn", {31'd0, outn_o}, 0);
        chk("mid_reset_outd_cnt", OUTD_CNT, 0);
        @(negedge clk); reset_i = 0;
        tick();
        chk("post_reset_hold1", {31'd0, outd_o}, 0);
        tick();
        chk("post_reset_hold2", {31'd0, outd_o}, 0);
        chk("post_reset_count", COUNT, 0);
        @(negedge clk); inp_i = 0;
        tick();
        chk("post_reset_low", {31'd0, outd_o}, 0);
        @(negedge clk); inp_i = 1;
        tick();
        chk("fresh_edge_outd", {31'd0, outd_o}, 1);
        chk("fresh_edge_outn", {31'd0, outn_o}, 0);
        chk("fresh_edge_outd_cnt", OUTD_CNT, OC_EN ? 1 : 0);
        @(negedge clk); inp_i = 0;
        tick();
        chk("fresh_edge_fall", {31'd0, outd_o}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_div.md
PULSE_DIV -- requirements
Module: pulse_div

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk_i  in  1  system clock; all logic on rising edge.
REQ-003 reset_i  in  1  reset, synchronous, active-high.
REQ-004 inp_i  in  1  pulse input to be divided.
REQ-005 enable_i  in  1  block enable; low forces idle.
REQ-006 DIVISOR  in  32  division ratio, unsigned.
REQ-007 DIVISOR_WSTB  in  1  one-cycle write strobe for DIVISOR.
REQ-008 FIRST_PULSE  in  1  initial routing: 0 = first edge to outn_o, 1 = first edge to outd_o.
REQ-009 FIRST_PULSE_WSTB  in  1  one-cycle write strobe for FIRST_PULSE.
REQ-010 outd_o  out  1  divided output: every DIVISOR-th pulse; feeds the downstream pulse block inp_i.
REQ-011 outn_o  out  1  non-divided output: all other pulses.
REQ-012 COUNT  out  32  current internal count readback.
REQ-013 OUTD_CNT  out  32  number of pulses routed to outd_o; see Configuration.

Function
REQ-014 Rising edge: inp_i=1 in a cycle where the registered previous inp_i=0.
REQ-015 Effective divisor D = DIVISOR, except DIVISOR=0 SHALL be treated as D=1.
REQ-016 Initial count = 0 if FIRST_PULSE=0, D-1 if FIRST_PULSE=1.
REQ-017 On a rising edge with enable_i=1: if count = D-1, route to D and set count to 0; otherwise route to N and increment count.
REQ-018 Route is decided once per rising edge and held until inp_i falls.
REQ-019 Latency: the routed output goes high the cycle after the rising edge is sampled, stays high while inp_i is high, and goes low the cycle after inp_i is sampled low.
REQ-020 outd_o and outn_o SHALL never be high in the same cycle.
REQ-021 A count outside [0, D-1] after a DIVISOR change SHALL be treated as D-1 on the next edge, so the next pulse goes to outd_o and count wraps to 0.
REQ-022 DIVISOR_WSTB or FIRST_PULSE_WSTB SHALL reload count to its initial value using the new register values.
REQ-023 A strobe coinciding with a rising edge: reload first, then process the edge from the reloaded count in the same cycle.
REQ-024 enable_i low: both outputs 0 on the next cycle, count held at its initial value, and edges ignored.
REQ-025 enable_i falling mid-pulse: the active output drops the next cycle.
REQ-026 enable_i rising: count reloads to its initial value.
REQ-027 If inp_i is already high when enable_i rises, no edge is counted until inp_i goes low and high again.
REQ-028 COUNT SHALL show the registered count, updated the cycle after each edge or reload.

Reset
REQ-029 reset_i high SHALL set outd_o=0, outn_o=0, previous-inp register=0, and OUTD_CNT=0.
REQ-030 reset_i high SHALL set COUNT to the initial value computed from the current DIVISOR and FIRST_PULSE inputs.
REQ-031 Reset mid-pulse: outputs go low the next cycle, and the still-high inp_i is not counted as an edge after reset.
REQ-032 reset_i SHALL take precedence over strobes, enable, and edges.

Configuration
REQ-033 Macro PULSE_DIV_OUTD_CNT_EN defined: OUTD_CNT increments by 1 for each pulse routed to outd_o.
REQ-034 With the macro, OUTD_CNT saturates at 0xFFFFFFFF and clears on reset_i or enable_i rising.
REQ-035 Macro undefined: OUTD_CNT is tied to 0 with no counter logic; the port remains present.

Verification
REQ-036 DIVISOR=3, FIRST_PULSE=0, enable=1, six 2-cycle inp pulses -> outn,outn,outd,outn,outn,outd, each delayed 1 cycle, 2 cycles wide; COUNT sequence 1,2,0,1,2,0.
REQ-037 DIVISOR=3, FIRST_PULSE=1 -> first pulse on outd_o, then outn,outn,outd; COUNT 0,1,2,0.
REQ-038 DIVISOR=0 -> every pulse on outd_o, outn_o stays 0.
REQ-039 After 2 edges at DIVISOR=4, FIRST_PULSE=0, pulse DIVISOR_WSTB with DIVISOR=2 on the same cycle as an edge -> that edge goes to outn_o, COUNT=1, and the next edge goes to outd_o.
REQ-040 enable_i drops while outd_o high -> outd_o=0 the next cycle; re-enable -> COUNT reloads and the sequence restarts from FIRST_PULSE.
REQ-041 reset_i asserted mid-pulse with inp_i held high -> outputs 0 next cycle, no output until the next fresh rising edge, and OUTD_CNT=0 with the macro defined.
